rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Arbitrates the single register-file write port between two requesters: the pipeline writeback stage and an external host/loader port.
- Writeback has fixed priority. Host writes are buffered in a small FIFO and drained in idle writeback cycles.
- A starvation guard stalls pipeline fetch/decode so that queued host writes always complete.
- Sits between the WB stage / host loader and the register file write port (address, data, write enable).

Parameters:
- DPW, 32, data path width
- ADW, 5, register address width
- FIFO_DEPTH, 2, host write buffer entries (power of two, >=2)
- STARVE_LIM, 4, consecutive blocked cycles before stall_o asserts (>=1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_we_i  in  1  writeback write request
- wb_addr_i  in  ADW  writeback destination register
- wb_data_i  in  DPW  writeback data
- host_valid_i  in  1  host write request valid
- host_ready_o  out  1  host request accepted this cycle when high with valid
- host_addr_i  in  ADW  host destination register
- host_data_i  in  DPW  host write data
- rf_we_o  out  1  register file write enable (registered)
- rf_addr_o  out  ADW  register file write address (registered)
- rf_wd_o  out  DPW  register file write data (registered)
- rf_src_o  out  1  source of current rf write: 0 = WB, 1 = host (registered)
- stall_o  out  1  freeze fetch/decode request to pipeline (registered)
- host_pend_o  out  1  FIFO non-empty

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty and pointers 0; rf_we_o, rf_addr_o, rf_wd_o, rf_src_o, stall_o, host_pend_o = 0; starve counter = 0; host_ready_o = 1 once reset is released. Reset mid-operation discards all queued host writes.
- Effective WB request: wb_act = wb_we_i && (wb_addr_i != 0). Writes to x0 never reach the register file.
- Host push: on the edge where host_valid_i && host_ready_o.
  - host_ready_o = !full, combinational from the occupancy count.
  - No pass-through: a host write always enters the FIFO first.
  - When full, host_ready_o = 0 and the request must be held by the host.
- Pop: on the edge where the FIFO is non-empty at cycle start and !wb_act. A push and a pop in the same cycle are both performed and occupancy is unchanged.
- Output register, updated every edge:
  - if wb_act: rf_we_o=1, addr/data from WB, rf_src_o=0;
  - else if pop and head addr != 0: rf_we_o=1, addr/data from FIFO head, rf_src_o=1;
  - else: rf_we_o=0 (addr/data/src hold their last values).
  - A popped host entry addressed to x0 consumes its slot but produces no write.
- Latency:
  - WB request in cycle N -> rf_we_o high in cycle N+1.
  - Host accepted at edge k into an empty FIFO with WB idle -> popped at edge k+1 -> rf_we_o high in the cycle after edge k+1.
- Ordering:
  - Host writes retire in FIFO order.
  - If WB and a queued host entry target the same register, the later-retiring write (the host entry) is the final value.
- Starvation:
  - starve_cnt increments on each edge where the FIFO is non-empty and wb_act blocks the pop; it saturates at STARVE_LIM.
  - starve_cnt clears on any pop or when the FIFO is empty.
  - stall_o is set on the edge where starve_cnt reaches STARVE_LIM and stays 1 until the first pop; it clears on the edge following that pop.
  - The pipeline is responsible for draining in-flight WB traffic. No timeout beyond this.
- host_pend_o = occupancy != 0, combinational.
- Pointer wrap-around: modulo FIFO_DEPTH; full/empty are distinguished by an explicit occupancy count (0..FIFO_DEPTH).

Test Plan:
- Reset, then idle inputs -> all outputs 0, host_ready_o=1, host_pend_o=0; assert rst_n low mid-queue with 2 entries -> host_pend_o=0 and rf_we_o=0 immediately.
- WB only: wb_we_i=1, addr=5, data=0xDEADBEEF in cycle N -> rf_we_o=1, rf_addr_o=5, rf_wd_o=0xDEADBEEF, rf_src_o=0 in cycle N+1; addr=0 -> rf_we_o=0.
- Host only: push (addr 21, data 0x12345678) with WB idle -> host write appears 2 cycles after the accepting edge, rf_src_o=1; a third push while 2 entries are blocked -> host_ready_o=0.
- Contention: queue (22, 0xA), hold wb_we_i=1 to addr 7 for 4 cycles -> stall_o=1 after the 4th blocked edge; drop wb_we_i -> host write to 22 next cycle, stall_o=0 one edge later.
- Same address: queue (9, 0x1111), WB writes (9, 0x2222) in the same cycle -> WB retires first, host second; final rf write to 9 = 0x1111.
- Host x0 entry followed by (23, 0x5) -> the x0 entry produces no write; 23 is written on the next idle cycle.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bundle: writeback request, host loader handshake,
// and the registered register-file write outputs.
interface rf_wr_arbiter_if #(
    parameter int DPW = 32,
    parameter int ADW = 5
);
    logic           wb_we_i;
    logic [ADW-1:0] wb_addr_i;
    logic [DPW-1:0] wb_data_i;
    logic           host_valid_i;
    logic           host_ready_o;
    logic [ADW-1:0] host_addr_i;
    logic [DPW-1:0] host_data_i;
    logic           rf_we_o;
    logic [ADW-1:0] rf_addr_o;
    logic [DPW-1:0] rf_wd_o;
    logic           rf_src_o;
    logic           stall_o;
    logic           host_pend_o;

    modport slave (
        input  wb_we_i, wb_addr_i, wb_data_i,
        input  host_valid_i, host_addr_i, host_data_i,
        output host_ready_o,
        output rf_we_o, rf_addr_o, rf_wd_o, rf_src_o,
        output stall_o, host_pend_o
    );

    modport master (
        output wb_we_i, wb_addr_i, wb_data_i,
        output host_valid_i, host_addr_i, host_data_i,
        input  host_ready_o,
        input  rf_we_o, rf_addr_o, rf_wd_o, rf_src_o,
        input  stall_o, host_pend_o
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has fixed priority, host writes
// are queued and drained in idle writeback cycles, with a starvation stall.
module rf_wr_arbiter #(
    parameter int DPW        = 32,
    parameter int ADW        = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_wr_arbiter_if.slave      bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [ADW-1:0] fifoAddr [FIFO_DEPTH];
    logic [DPW-1:0] fifoData [FIFO_DEPTH];
    logic [PW-1:0]  wrPtr, rdPtr;
    logic [CW-1:0]  occ;
    logic [SW-1:0]  starveCnt;
    logic           popD;

    logic wbAct, full, empty, push, pop;
    logic [ADW-1:0] headAddr;
    logic [DPW-1:0] headData;

    assign wbAct    = bus.wb_we_i && (bus.wb_addr_i != '0);
    assign full     = (occ == CW'(FIFO_DEPTH));
    assign empty    = (occ == '0);
    assign push     = bus.host_valid_i && !full;
    assign pop      = !empty && !wbAct;
    assign headAddr = fifoAddr[rdPtr];
    assign headData = fifoData[rdPtr];

    assign bus.host_ready_o = !full;
    assign bus.host_pend_o  = !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr] <= bus.host_addr_i;
            fifoData[wrPtr] <= bus.host_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            occ           <= '0;
            starveCnt     <= '0;
            popD          <= 1'b0;
            bus.stall_o   <= 1'b0;
            bus.rf_we_o   <= 1'b0;
            bus.rf_addr_o <= '0;
            bus.rf_wd_o   <= '0;
            bus.rf_src_o  <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;

            // Non-empty without a pop can only mean writeback blocked the drain.
            if (pop || empty)
                starveCnt <= '0;
            else if (starveCnt != SW'(STARVE_LIM))
                starveCnt <= starveCnt + 1'b1;

            // Stall drops one edge after the pop so the pipeline sees the drain retire.
            popD <= pop;
            if (!empty && wbAct && starveCnt == SW'(STARVE_LIM - 1))
                bus.stall_o <= 1'b1;
            else if (popD)
                bus.stall_o <= 1'b0;

            if (wbAct) begin
                bus.rf_we_o   <= 1'b1;
                bus.rf_addr_o <= bus.wb_addr_i;
                bus.rf_wd_o   <= bus.wb_data_i;
                bus.rf_src_o  <= 1'b0;
            end else if (pop && headAddr != '0) begin
                bus.rf_we_o   <= 1'b1;
                bus.rf_addr_o <= headAddr;
                bus.rf_wd_o   <= headData;
                bus.rf_src_o  <= 1'b1;
            end else begin
                bus.rf_we_o   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: reset, WB path, host path, contention,
// same-address ordering and x0 host entries.
module tb_rf_wr_arbiter;
    logic clk;
    logic rst_n;
    int   nCmp;
    int   nErr;

    rf_wr_arbiter_if #(.DPW(32), .ADW(5)) bus ();

    rf_wr_arbiter #(
        .DPW(32), .ADW(5), .FIFO_DEPTH(2), .STARVE_LIM(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setWb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i   = we;
        bus.wb_addr_i = a;
        bus.wb_data_i = d;
    endtask

    task automatic setHost(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.host_valid_i = v;
        bus.host_addr_i  = a;
        bus.host_data_i  = d;
    endtask

    initial begin
        nCmp = 0;
        nErr = 0;
        rst_n = 1'b0;
        setWb(1'b0, 5'd0, 32'h0);
        setHost(1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset / idle state
        chk("rst_we",    64'(bus.rf_we_o),      64'd0);
        chk("rst_addr",  64'(bus.rf_addr_o),    64'd0);
        chk("rst_wd",    64'(bus.rf_wd_o),      64'd0);
        chk("rst_src",   64'(bus.rf_src_o),     64'd0);
        chk("rst_stall", 64'(bus.stall_o),      64'd0);
        chk("rst_pend",  64'(bus.host_pend_o),  64'd0);
        chk("rst_ready", 64'(bus.host_ready_o), 64'd1);

        // WB only
        setWb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk("wb_we",   64'(bus.rf_we_o),   64'd1);
        chk("wb_addr", 64'(bus.rf_addr_o), 64'd5);
        chk("wb_wd",   64'(bus.rf_wd_o),   64'hDEADBEEF);
        chk("wb_src",  64'(bus.rf_src_o),  64'd0);
        setWb(1'b1, 5'd0, 32'h55);
        tick();
        chk("wb_x0_we",   64'(bus.rf_we_o),   64'd0);
        chk("wb_x0_addr", 64'(bus.rf_addr_o), 64'd5);
        setWb(1'b0, 5'd0, 32'h0);

        // Host only: accepted at edge k, written after edge k+1
        setHost(1'b1, 5'd21, 32'h12345678);
        tick();
        setHost(1'b0, 5'd0, 32'h0);
        chk("h_pend1", 64'(bus.host_pend_o), 64'd1);
        chk("h_we0",   64'(bus.rf_we_o),     64'd0);
        tick();
        chk("h_we",    64'(bus.rf_we_o),     64'd1);
        chk("h_addr",  64'(bus.rf_addr_o),   64'd21);
        chk("h_wd",    64'(bus.rf_wd_o),     64'h12345678);
        chk("h_src",   64'(bus.rf_src_o),    64'd1);
        chk("h_pend0", 64'(bus.host_pend_o), 64'd0);

        // Fill FIFO while WB blocks, third push refused, then mid-queue reset
        setWb(1'b1, 5'd3, 32'h1);
        setHost(1'b1, 5'd1, 32'h100);
        tick();
        setHost(1'b1, 5'd2, 32'h200);
        tick();
        chk("full_ready", 64'(bus.host_ready_o), 64'd0);
        chk("full_pend",  64'(bus.host_pend_o),  64'd1);
        setHost(1'b1, 5'd4, 32'h400);
        tick();
        chk("full_ready2", 64'(bus.host_ready_o), 64'd0);
        chk("full_stall",  64'(bus.stall_o),      64'd0);
        setHost(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mrst_pend",  64'(bus.host_pend_o),  64'd0);
        chk("mrst_we",    64'(bus.rf_we_o),      64'd0);
        chk("mrst_ready", 64'(bus.host_ready_o), 64'd1);
        setWb(1'b0, 5'd0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_we2", 64'(bus.rf_we_o), 64'd0);

        // Contention: WB to 7 blocks queued (22, 0xA)
        setHost(1'b1, 5'd22, 32'hA);
        setWb(1'b1, 5'd7, 32'h77);
        tick();
        setHost(1'b0, 5'd0, 32'h0);
        chk("c_wb_addr", 64'(bus.rf_addr_o), 64'd7);
        chk("c_stall0",  64'(bus.stall_o),   64'd0);
        repeat (3) tick();
        chk("c_stall3",  64'(bus.stall_o),   64'd0);
        tick();
        chk("c_stall4",  64'(bus.stall_o),   64'd1);
        chk("c_src4",    64'(bus.rf_src_o),  64'd0);
        setWb(1'b0, 5'd0, 32'h0);
        tick();
        chk("c_h_we",    64'(bus.rf_we_o),   64'd1);
        chk("c_h_addr",  64'(bus.rf_addr_o), 64'd22);
        chk("c_h_wd",    64'(bus.rf_wd_o),   64'hA);
        chk("c_h_src",   64'(bus.rf_src_o),  64'd1);
        chk("c_stall_h", 64'(bus.stall_o),   64'd1);
        tick();
        chk("c_stall_clr", 64'(bus.stall_o), 64'd0);
        chk("c_we_idle",   64'(bus.rf_we_o), 64'd0);

        // Same address: WB retires first, host last
        setHost(1'b1, 5'd9, 32'h1111);
        setWb(1'b1, 5'd9, 32'h2222);
        tick();
        setHost(1'b0, 5'd0, 32'h0);
        setWb(1'b0, 5'd0, 32'h0);
        chk("sa_wb_wd",  64'(bus.rf_wd_o),   64'h2222);
        chk("sa_wb_src", 64'(bus.rf_src_o),  64'd0);
        tick();
        chk("sa_h_we",   64'(bus.rf_we_o),   64'd1);
        chk("sa_h_addr", 64'(bus.rf_addr_o), 64'd9);
        chk("sa_h_wd",   64'(bus.rf_wd_o),   64'h1111);
        chk("sa_h_src",  64'(bus.rf_src_o),  64'd1);

        // Host x0 entry consumes a slot without writing
        setHost(1'b1, 5'd0, 32'hFF);
        tick();
        chk("x0_pend", 64'(bus.host_pend_o), 64'd1);
        setHost(1'b1, 5'd23, 32'h5);
        tick();
        setHost(1'b0, 5'd0, 32'h0);
        chk("x0_we",    64'(bus.rf_we_o),     64'd0);
        chk("x0_pend2", 64'(bus.host_pend_o), 64'd1);
        tick();
        chk("x23_we",   64'(bus.rf_we_o),     64'd1);
        chk("x23_addr", 64'(bus.rf_addr_o),   64'd23);
        chk("x23_wd",   64'(bus.rf_wd_o),     64'h5);
        chk("x23_src",  64'(bus.rf_src_o),    64'd1);
        chk("x23_pend", 64'(bus.host_pend_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
